// File: rtl/reg_read_scoreboard_if.sv
// rtl/reg_read_scoreboard_if.sv - decode/issue/writeback bundle for the read-port interlock
interface reg_read_scoreboard_if #(
  parameter int CNT_W = 3
);
  logic             flush;
  logic             issue_valid;
  logic [4:0]       rs1_sel;
  logic             rs1_used;
  logic [4:0]       rs2_sel;
  logic             rs2_used;
  logic [4:0]       rd_sel;
  logic             rd_we;
  logic             wb_valid;
  logic [4:0]       wb_sel;
  logic             stall;
  logic             issue_ok;
  logic [31:0]      busy_vec;
  logic [CNT_W-1:0] outstanding;
  logic             wb_error;
  logic [15:0]      stall_cycles;

  // decode/writeback side drives the request, observes the interlock
  modport master (
    output flush, issue_valid, rs1_sel, rs1_used, rs2_sel, rs2_used,
           rd_sel, rd_we, wb_valid, wb_sel,
    input  stall, issue_ok, busy_vec, outstanding, wb_error, stall_cycles
  );

  // scoreboard side
  modport slave (
    input  flush, issue_valid, rs1_sel, rs1_used, rs2_sel, rs2_used,
           rd_sel, rd_we, wb_valid, wb_sel,
    output stall, issue_ok, busy_vec, outstanding, wb_error, stall_cycles
  );
endinterface

// File: rtl/reg_read_scoreboard.sv
// rtl/reg_read_scoreboard.sv - RAW/WAW interlock with pending-write tracking and stall counter
module reg_read_scoreboard #(
  parameter int MAX_OUT   = 4,
  parameter int CNT_W     = 3,
  parameter int WB_BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_read_scoreboard_if.slave bus
);
  localparam logic             BYP   = (WB_BYPASS != 0);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

  logic [31:0]      busy_q;
  logic [31:0]      busy_d;
  logic [CNT_W-1:0] out_q;
  logic             err_q;
  logic [15:0]      sc_q;

  logic legal_wb;
  logic rd_wr;
  logic haz1, haz2, hazd;
  logic full;
  logic stall_c;
  logic ok_c;
  logic do_set;
  logic do_clr;

  // hazard evaluation; a legal writeback to the same register hides the hazard when bypass is on
  always_comb begin
    legal_wb = bus.wb_valid && (bus.wb_sel != 5'd0) && busy_q[bus.wb_sel];
    rd_wr    = bus.rd_we && (bus.rd_sel != 5'd0);
    haz1     = busy_q[bus.rs1_sel] && !(BYP && legal_wb && (bus.wb_sel == bus.rs1_sel));
    haz2     = busy_q[bus.rs2_sel] && !(BYP && legal_wb && (bus.wb_sel == bus.rs2_sel));
    hazd     = busy_q[bus.rd_sel]  && !(BYP && legal_wb && (bus.wb_sel == bus.rd_sel));
    full     = (out_q == MAX_C) && !(BYP && legal_wb);
    stall_c  = bus.issue_valid && !bus.flush &&
               ((bus.rs1_used && haz1) || (bus.rs2_used && haz2) ||
                (rd_wr && hazd) || (rd_wr && full));
    ok_c     = bus.issue_valid && !stall_c && !bus.flush;
    do_set   = ok_c && rd_wr;
    do_clr   = legal_wb && !bus.flush;
  end

  // next pending vector: clear first so a same-register set wins
  always_comb begin
    busy_d = busy_q;
    if (do_clr) busy_d[bus.wb_sel] = 1'b0;
    if (do_set) busy_d[bus.rd_sel] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // pending state, outstanding count, error pulse and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 32'd0;
      out_q  <= '0;
      err_q  <= 1'b0;
      sc_q   <= 16'd0;
    end else begin
      if (bus.flush) begin
        busy_q <= 32'd0;
        out_q  <= '0;
        err_q  <= 1'b0;
      end else begin
        busy_q <= busy_d;
        case ({do_set, do_clr})
          2'b10:   out_q <= out_q + CNT_W'(1);
          2'b01:   out_q <= out_q - CNT_W'(1);
          default: out_q <= out_q;
        endcase
        err_q <= bus.wb_valid && !legal_wb;
      end
      if (stall_c && (sc_q != 16'hFFFF)) sc_q <= sc_q + 16'd1;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.issue_ok     = ok_c;
  assign bus.busy_vec     = busy_q;
  assign bus.outstanding  = out_q;
  assign bus.wb_error     = err_q;
  assign bus.stall_cycles = sc_q;
endmodule

// File: tb/tb_reg_read_scoreboard.sv
// tb/tb_reg_read_scoreboard.sv - directed scoreboard bench for reg_read_scoreboard
module tb_reg_read_scoreboard;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [15:0] exp_sc;

  typedef struct {
    string     tag;
    logic      stall;
    logic      ok;
  } comb_exp_t;

  typedef struct {
    string       tag;
    logic [31:0] busy;
    logic [2:0]  outst;
    logic        err;
    logic [15:0] sc;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];

  reg_read_scoreboard_if #(.CNT_W(3)) bus ();

  reg_read_scoreboard #(.MAX_OUT(4), .CNT_W(3), .WB_BYPASS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // one directed cycle: drive, check combinational outputs, clock, check registered outputs
  task automatic step(input string tag, input bit iv,
                      input bit [4:0] r1, input bit u1, input bit [4:0] r2, input bit u2,
                      input bit [4:0] rd, input bit we, input bit wv, input bit [4:0] ws,
                      input bit fl, input bit e_stall, input bit e_ok,
                      input bit [31:0] e_busy, input bit [2:0] e_out, input bit e_err);
    comb_exp_t c;
    reg_exp_t  r;
    bus.issue_valid = iv;
    bus.rs1_sel = r1; bus.rs1_used = u1;
    bus.rs2_sel = r2; bus.rs2_used = u2;
    bus.rd_sel  = rd; bus.rd_we    = we;
    bus.wb_valid = wv; bus.wb_sel  = ws;
    bus.flush   = fl;
    comb_q.push_back('{tag, e_stall, e_ok});
    if (e_stall && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    reg_q.push_back('{tag, e_busy, e_out, e_err, exp_sc});
    #1;
    c = comb_q.pop_front();
    chk({c.tag, ".stall"}, 32'(bus.stall), 32'(c.stall));
    chk({c.tag, ".issue_ok"}, 32'(bus.issue_ok), 32'(c.ok));
    @(posedge clk);
    #1;
    r = reg_q.pop_front();
    chk({r.tag, ".busy_vec"}, bus.busy_vec, r.busy);
    chk({r.tag, ".outstanding"}, 32'(bus.outstanding), 32'(r.outst));
    chk({r.tag, ".wb_error"}, 32'(bus.wb_error), 32'(r.err));
    chk({r.tag, ".stall_cycles"}, 32'(bus.stall_cycles), 32'(r.sc));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 1'b0; bus.rs1_sel = 5'd0; bus.rs1_used = 1'b0;
    bus.rs2_sel = 5'd0; bus.rs2_used = 1'b0; bus.rd_sel = 5'd0; bus.rd_we = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_sel = 5'd0; bus.flush = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_sc = 16'd0;
    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk("reset.busy_vec", bus.busy_vec, 32'd0);
    chk("reset.outstanding", 32'(bus.outstanding), 32'd0);
    chk("reset.wb_error", 32'(bus.wb_error), 32'd0);
    chk("reset.stall_cycles", 32'(bus.stall_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //   tag            iv r1 u1 r2 u2 rd we wv ws fl  stall ok  busy          out err
    step("acc_r5",      1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 1, 32'h0000_0020, 1, 0);
    step("raw_r5",      1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0020, 1, 0);
    step("raw_wb_byp",  1, 5, 1, 0, 0, 0, 0, 1, 5, 0,  0, 1, 32'h0000_0000, 0, 0);
    step("acc_r1",      1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 1, 32'h0000_0002, 1, 0);
    step("acc_r2",      1, 0, 0, 0, 0, 2, 1, 0, 0, 0,  0, 1, 32'h0000_0006, 2, 0);
    step("acc_r3",      1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 1, 32'h0000_000E, 3, 0);
    step("acc_r4",      1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  0, 1, 32'h0000_001E, 4, 0);
    step("full_stall",  1, 0, 0, 0, 0, 6, 1, 0, 0, 0,  1, 0, 32'h0000_001E, 4, 0);
    step("full_wb_r1",  1, 0, 0, 0, 0, 6, 1, 1, 1, 0,  0, 1, 32'h0000_005C, 4, 0);
    step("rd0_nowrite", 1, 0, 0, 0, 0, 0, 1, 1, 2, 0,  0, 1, 32'h0000_0058, 3, 0);
    step("wb_r3",       0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0, 0, 32'h0000_0050, 2, 0);
    step("wb_r4",       0, 0, 0, 0, 0, 0, 0, 1, 4, 0,  0, 0, 32'h0000_0040, 1, 0);
    step("wb_r6",       0, 0, 0, 0, 0, 0, 0, 1, 6, 0,  0, 0, 32'h0000_0000, 0, 0);
    step("acc_r7",      1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h0000_0080, 1, 0);
    step("waw_stall",   1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 32'h0000_0080, 1, 0);
    step("waw_byp",     1, 0, 0, 0, 0, 7, 1, 1, 7, 0,  0, 1, 32'h0000_0080, 1, 0);
    step("raw_rs2",     1, 0, 0, 7, 1, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0080, 1, 0);
    step("rs1_unused",  1, 7, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0000_0080, 1, 0);
    step("iv0_nostall", 0, 7, 1, 7, 1, 7, 1, 0, 0, 0,  0, 0, 32'h0000_0080, 1, 0);
    step("ill_wb9",     0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  0, 0, 32'h0000_0080, 1, 1);
    step("ill_wb0",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 32'h0000_0080, 1, 1);
    step("err_clear",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_0080, 1, 0);
    step("acc_r8",      1, 0, 0, 0, 0, 8, 1, 0, 0, 0,  0, 1, 32'h0000_0180, 2, 0);
    step("acc_r9",      1, 0, 0, 0, 0, 9, 1, 0, 0, 0,  0, 1, 32'h0000_0380, 3, 0);
    step("flush",       1, 7, 1, 0, 0,10, 1, 1, 8, 1,  0, 0, 32'h0000_0000, 0, 0);
    step("post_flush",  1, 7, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0000_0000, 0, 0);
    step("acc_r2b",     1, 0, 0, 0, 0, 2, 1, 0, 0, 0,  0, 1, 32'h0000_0004, 1, 0);
    step("acc_r5b",     1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 1, 32'h0000_0024, 2, 0);

    // asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.busy_vec", bus.busy_vec, 32'd0);
    chk("async_rst.outstanding", 32'(bus.outstanding), 32'd0);
    chk("async_rst.wb_error", 32'(bus.wb_error), 32'd0);
    chk("async_rst.stall_cycles", 32'(bus.stall_cycles), 32'd0);
    exp_sc = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();

    // saturation of the stall counter under a held RAW hazard
    step("sat_acc_r5",  1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 1, 32'h0000_0020, 1, 0);
    bus.issue_valid = 1'b1; bus.rs1_sel = 5'd5; bus.rs1_used = 1'b1;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    chk("sat.stall", 32'(bus.stall), 32'd1);
    chk("sat.stall_cycles", 32'(bus.stall_cycles), 32'h0000_FFFF);
    @(posedge clk);
    #1;
    chk("sat_hold.stall_cycles", 32'(bus.stall_cycles), 32'h0000_FFFF);
    @(negedge clk);
    exp_sc = 16'hFFFF;
    step("sat_flush",   1, 5, 1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 32'h0000_0000, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
